// File: rtl/tdc_arb.sv
// Round-robin merge of NUM_CH TDC result streams into one AXI-Stream uplink.
// Each output word carries its source channel in tuser. Disabled channels are
// drained and discarded so their producers never stall.
module tdc_arb #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned CH_WIDTH   = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_s_axis_tdata,
  input  logic [NUM_CH-1:0]            i_s_axis_tvalid,
  output logic [NUM_CH-1:0]            o_s_axis_tready,
  input  logic [NUM_CH-1:0]            i_ch_en,
  output logic [DATA_WIDTH-1:0]        o_m_axis_tdata,
  output logic [CH_WIDTH-1:0]          o_m_axis_tuser,
  output logic                         o_m_axis_tvalid,
  input  logic                         i_m_axis_tready,
  output logic                         o_drop_stb
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CH_WIDTH-1:0]   user_q;
  logic [CH_WIDTH-1:0]   last_grant_q;
  logic                  drop_q;

  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     dis_ready;
  logic [NUM_CH-1:0]     en_ready;
  logic                  load_ok;
  logic                  any_req;
  logic                  hit_hi;
  logic [CH_WIDTH-1:0]   pick_hi;
  logic [CH_WIDTH-1:0]   pick_lo;
  logic [CH_WIDTH-1:0]   grant;
  logic [DATA_WIDTH-1:0] grant_data;

  assign req       = i_s_axis_tvalid & i_ch_en;
  assign dis_ready = i_s_axis_tvalid & ~i_ch_en;
  assign load_ok   = (state_q == StEmpty) || i_m_axis_tready;

  // Round-robin pick: lowest requester above last_grant, else lowest overall (wrap).
  always_comb begin
    any_req = 1'b0;
    hit_hi  = 1'b0;
    pick_hi = '0;
    pick_lo = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[k]) begin
        any_req = 1'b1;
        pick_lo = CH_WIDTH'(k);
        if (k > int'(last_grant_q)) begin
          hit_hi  = 1'b1;
          pick_hi = CH_WIDTH'(k);
        end
      end
    end
    grant = hit_hi ? pick_hi : pick_lo;
  end

  // Data mux and one-hot ready for the granted channel.
  always_comb begin
    grant_data = '0;
    en_ready   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (CH_WIDTH'(k) == grant) begin
        grant_data  = i_s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        en_ready[k] = load_ok && any_req;
      end
    end
  end

  // Ready is held low throughout reset; disabled channels always accept.
  always_comb begin
    o_s_axis_tready = '0;
    if (i_rst_n) begin
      o_s_axis_tready = en_ready | dis_ready;
    end
  end

  // Output register state, payload, round-robin pointer and drop strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StEmpty;
      data_q       <= '0;
      user_q       <= '0;
      last_grant_q <= CH_WIDTH'(NUM_CH - 1);
      drop_q       <= 1'b0;
    end else begin
      drop_q <= |dis_ready;
      if (load_ok) begin
        if (any_req) begin
          state_q      <= StFull;
          data_q       <= grant_data;
          user_q       <= grant;
          last_grant_q <= grant;
        end else begin
          state_q <= StEmpty;
        end
      end
    end
  end

  assign o_m_axis_tvalid = (state_q == StFull);
  assign o_m_axis_tdata  = data_q;
  assign o_m_axis_tuser  = user_q;
  assign o_drop_stb      = drop_q;

endmodule

// File: tb/tb_tdc_arb.sv
// Self-checking bench for tdc_arb: directed scenarios plus a randomized run
// against a behavioural arbiter model.
module tb_tdc_arb;

  localparam int NCH = 4;
  localparam int DW  = 96;
  localparam int CW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH-1:0]    s_tready;
  logic [NCH-1:0]    ch_en;
  logic [DW-1:0]     m_tdata;
  logic [CW-1:0]     m_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic              drop;

  int checks = 0;
  int errors = 0;

  tdc_arb #(
    .NUM_CH    (NCH),
    .DATA_WIDTH(DW),
    .CH_WIDTH  (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_s_axis_tdata (s_tdata),
    .i_s_axis_tvalid(s_tvalid),
    .o_s_axis_tready(s_tready),
    .i_ch_en        (ch_en),
    .o_m_axis_tdata (m_tdata),
    .o_m_axis_tuser (m_tuser),
    .o_m_axis_tvalid(m_tvalid),
    .i_m_axis_tready(m_tready),
    .o_drop_stb     (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    ch_en    = '1;
    m_tready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    s_tvalid = '1;
    s_tdata  = '1;
    ch_en    = '1;
    m_tready = 1'b1;
    #7;
    checks++;
    if (s_tready !== 4'b0000) begin
      errors++; $display("FAIL reset_tready got %b exp 0000", s_tready);
    end
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_tvalid got %b exp 0", m_tvalid);
    end
    checks++;
    if (m_tdata !== '0) begin
      errors++; $display("FAIL reset_tdata got %h exp 0", m_tdata);
    end
    checks++;
    if (m_tuser !== 2'd0) begin
      errors++; $display("FAIL reset_tuser got %0d exp 0", m_tuser);
    end
    checks++;
    if (drop !== 1'b0) begin
      errors++; $display("FAIL reset_drop got %b exp 0", drop);
    end
  endtask

  task automatic test_single;
    do_reset();
    s_tdata[2*DW +: DW] = 96'h0AB;
    s_tvalid = 4'b0100;
    #2;
    checks++;
    if (s_tready !== 4'b0100) begin
      errors++; $display("FAIL single_tready got %b exp 0100", s_tready);
    end
    tick();
    s_tvalid = '0;
    #2;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 96'h0AB || m_tuser !== 2'd2) begin
      errors++;
      $display("FAIL single_out got v=%b d=%h u=%0d exp v=1 d=0ab u=2", m_tvalid, m_tdata, m_tuser);
    end
    tick();
    #2;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL single_empty got %b exp 0", m_tvalid);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    for (int k = 0; k < NCH; k++) s_tdata[k*DW +: DW] = DW'(32'h100 + k);
    s_tvalid = '1;
    for (int i = 0; i < 6; i++) begin
      tick();
      #2;
      checks++;
      if (m_tvalid !== 1'b1 || m_tuser !== CW'(i % NCH) || m_tdata !== DW'(32'h100 + i % NCH)) begin
        errors++;
        $display("FAIL rr_seq[%0d] got v=%b u=%0d d=%h exp v=1 u=%0d", i, m_tvalid, m_tuser,
                 m_tdata, i % NCH);
      end
    end
    s_tvalid = '0;
  endtask

  task automatic test_backpressure;
    do_reset();
    s_tvalid = 4'b0010;
    tick();
    s_tvalid = 4'b1001;
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++;
      if (m_tvalid !== 1'b1 || m_tuser !== 2'd1 || s_tready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b u=%0d rdy=%b exp v=1 u=1 rdy=0000", i, m_tvalid,
                 m_tuser, s_tready);
      end
      tick();
    end
    m_tready = 1'b1;
    #2;
    checks++;
    if (s_tready !== 4'b1000) begin
      errors++; $display("FAIL bp_release_rdy got %b exp 1000", s_tready);
    end
    tick();
    s_tvalid = 4'b0001;
    #2;
    checks++;
    if (m_tvalid !== 1'b1 || m_tuser !== 2'd3 || s_tready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_first got v=%b u=%0d rdy=%b exp v=1 u=3 rdy=0001", m_tvalid, m_tuser,
               s_tready);
    end
    tick();
    s_tvalid = '0;
    #2;
    checks++;
    if (m_tvalid !== 1'b1 || m_tuser !== 2'd0) begin
      errors++; $display("FAIL bp_second got v=%b u=%0d exp v=1 u=0", m_tvalid, m_tuser);
    end
  endtask

  task automatic test_disabled;
    do_reset();
    ch_en    = 4'b1101;
    s_tvalid = 4'b0010;
    #2;
    checks++;
    if (s_tready !== 4'b0010 || drop !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL dis_accept got rdy=%b drop=%b v=%b exp rdy=0010 drop=0 v=0", s_tready, drop,
               m_tvalid);
    end
    tick();
    s_tvalid = '0;
    #2;
    checks++;
    if (drop !== 1'b1 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL dis_pulse got drop=%b v=%b exp drop=1 v=0", drop, m_tvalid);
    end
    tick();
    #2;
    checks++;
    if (drop !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL dis_after got drop=%b v=%b exp drop=0 v=0", drop, m_tvalid);
    end
    ch_en = '1;
  endtask

  task automatic test_reset_mid_stall;
    do_reset();
    s_tvalid = 4'b0100;
    m_tready = 1'b0;
    tick();
    s_tvalid = '0;
    #2;
    checks++;
    if (m_tvalid !== 1'b1 || m_tuser !== 2'd2) begin
      errors++; $display("FAIL stall_full got v=%b u=%0d exp v=1 u=2", m_tvalid, m_tuser);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL async_reset got v=%b exp 0", m_tvalid);
    end
    tick();
    rst_n    = 1'b1;
    s_tvalid = 4'b1001;
    m_tready = 1'b1;
    #2;
    checks++;
    if (s_tready !== 4'b0001) begin
      errors++; $display("FAIL post_reset_rdy got %b exp 0001", s_tready);
    end
    tick();
    s_tvalid = 4'b1000;
    #2;
    checks++;
    if (m_tvalid !== 1'b1 || m_tuser !== 2'd0) begin
      errors++; $display("FAIL post_reset_grant got v=%b u=%0d exp v=1 u=0", m_tvalid, m_tuser);
    end
    tick();
    s_tvalid = '0;
  endtask

  task automatic test_idle_fairness;
    do_reset();
    s_tvalid = 4'b0010;
    tick();
    s_tvalid = '0;
    tick();
    s_tvalid = 4'b1001;
    #2;
    checks++;
    if (s_tready !== 4'b1000 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL idle_rdy got rdy=%b v=%b exp rdy=1000 v=0", s_tready, m_tvalid);
    end
    tick();
    s_tvalid = 4'b0001;
    #2;
    checks++;
    if (m_tuser !== 2'd3 || m_tvalid !== 1'b1 || s_tready !== 4'b0001) begin
      errors++;
      $display("FAIL idle_first got u=%0d v=%b rdy=%b exp u=3 v=1 rdy=0001", m_tuser, m_tvalid,
               s_tready);
    end
    tick();
    s_tvalid = '0;
    #2;
    checks++;
    if (m_tuser !== 2'd0 || m_tvalid !== 1'b1) begin
      errors++; $display("FAIL idle_second got u=%0d v=%b exp u=0 v=1", m_tuser, m_tvalid);
    end
  endtask

  // Model: one output slot, a pointer to the last served channel, and a
  // pending drop flag. The next served channel is the requester at the
  // smallest circular distance past the pointer.
  task automatic test_random;
    bit          mdl_valid;
    logic [DW-1:0] mdl_data;
    int          mdl_user;
    int          mdl_last;
    bit          mdl_drop;
    logic [NCH-1:0] exp_rdy;
    logic [NCH-1:0] req;
    bit          can_load;
    int          best;
    int          best_d;
    int          d;
    int          err_before;

    do_reset();
    mdl_valid = 0;
    mdl_data  = '0;
    mdl_user  = 0;
    mdl_last  = NCH - 1;
    mdl_drop  = 0;
    err_before = errors;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 15) == 0) ch_en = NCH'($urandom);
      s_tvalid = NCH'($urandom);
      m_tready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NCH; k++) s_tdata[k*DW +: DW] = {$urandom, $urandom, $urandom};
      #2;
      req      = s_tvalid & ch_en;
      can_load = !mdl_valid || m_tready;
      best     = -1;
      best_d   = NCH;
      for (int k = 0; k < NCH; k++) begin
        if (req[k]) begin
          d = (k - mdl_last - 1 + 2 * NCH) % NCH;
          if (d < best_d) begin
            best_d = d;
            best   = k;
          end
        end
      end
      exp_rdy = s_tvalid & ~ch_en;
      if (can_load && best >= 0) exp_rdy[best] = 1'b1;

      checks++;
      if (s_tready !== exp_rdy) begin
        errors++; $display("FAIL rnd_tready cyc %0d got %b exp %b", cyc, s_tready, exp_rdy);
      end
      checks++;
      if (m_tvalid !== mdl_valid || drop !== mdl_drop) begin
        errors++;
        $display("FAIL rnd_ctrl cyc %0d got v=%b drop=%b exp v=%b drop=%b", cyc, m_tvalid, drop,
                 mdl_valid, mdl_drop);
      end
      if (mdl_valid) begin
        checks++;
        if (m_tdata !== mdl_data || m_tuser !== CW'(mdl_user)) begin
          errors++;
          $display("FAIL rnd_data cyc %0d got u=%0d d=%h exp u=%0d d=%h", cyc, m_tuser, m_tdata,
                   mdl_user, mdl_data);
        end
      end
      if (errors - err_before > 20) break;

      mdl_drop = |(s_tvalid & ~ch_en);
      if (can_load) begin
        if (best >= 0) begin
          mdl_valid = 1;
          mdl_data  = s_tdata[best*DW +: DW];
          mdl_user  = best;
          mdl_last  = best;
        end else begin
          mdl_valid = 0;
        end
      end
      tick();
    end
    s_tvalid = '0;
    ch_en    = '1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_disabled();
    test_reset_mid_stall();
    test_idle_fairness();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
